// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: default datapath widths and the hard-wired zero register.
package mips_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned COUNT_W  = 32;

endpackage

// File: rtl/writeback_regfile_wb_select.sv
// Write-back value selection and commit qualification; pure combinational so the
// forwarding unit can reuse it.
module wb_select #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] AluIn,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] wbData,
    output logic              wbValid
);
    import mips_pkg::REG_ZERO;

    always_comb begin
        wbData = AluIn;
        if (MemtoReg) begin
            wbData = MemDataIn;
        end
    end

    // Writes aimed at the zero register never commit.
    always_comb begin
        wbValid = RegWrite && (writeReg != ADDR_W'(REG_ZERO));
    end

endmodule

// File: rtl/writeback_regfile.sv
// Write-back stage plus register file: commits the selected MEM/WB value and serves the
// two ID read ports with same-cycle write-through bypass.
module writeback_regfile #(
    parameter int unsigned DATA_W = mips_pkg::DATA_W,
    parameter int unsigned ADDR_W = mips_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] AluIn,
    input  logic [DATA_W-1:0] MemDataIn,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    output logic [DATA_W-1:0] wbData,
    output logic              wbValid,
    output logic [31:0]       wbCount
);
    import mips_pkg::REG_ZERO;

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NumRegs];

    wb_select #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_wb_select (
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .AluIn     (AluIn),
        .MemDataIn (MemDataIn),
        .writeReg  (writeReg),
        .wbData    (wbData),
        .wbValid   (wbValid)
    );

    // Register array; entry 0 is never written because wbValid excludes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NumRegs); i++) begin
                regs[i] <= '0;
            end
        end else if (wbValid) begin
            regs[writeReg] <= wbData;
        end
    end

    // Committed-write counter, wraps naturally at 2**32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbCount <= '0;
        end else if (wbValid) begin
            wbCount <= wbCount + 32'd1;
        end
    end

    // Read port 1: zero register, then bypass of this edge's commit, then stored value.
    always_comb begin
        readData1 = '0;
        if (reset || (readReg1 == ADDR_W'(REG_ZERO))) begin
            readData1 = '0;
        end else if (wbValid && (writeReg == readReg1)) begin
            readData1 = wbData;
        end else begin
            readData1 = regs[readReg1];
        end
    end

    // Read port 2: identical rules, evaluated independently.
    always_comb begin
        readData2 = '0;
        if (reset || (readReg2 == ADDR_W'(REG_ZERO))) begin
            readData2 = '0;
        end else if (wbValid && (writeReg == readReg2)) begin
            readData2 = wbData;
        end else begin
            readData2 = regs[readReg2];
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: a driver pushes expected outputs computed from an
// array model of the register file, and a monitor pops and compares them every cycle.
module tb_writeback_regfile;

    localparam int unsigned NR = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemtoReg = 1'b0;
    logic        RegWrite = 1'b0;
    logic [31:0] AluIn = '0;
    logic [31:0] MemDataIn = '0;
    logic [4:0]  writeReg = '0;
    logic [4:0]  readReg1 = '0;
    logic [4:0]  readReg2 = '0;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] wbData;
    logic        wbValid;
    logic [31:0] wbCount;

    writeback_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .AluIn     (AluIn),
        .MemDataIn (MemDataIn),
        .writeReg  (writeReg),
        .readReg1  (readReg1),
        .readReg2  (readReg2),
        .readData1 (readData1),
        .readData2 (readData2),
        .wbData    (wbData),
        .wbValid   (wbValid),
        .wbCount   (wbCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wbd;
        logic        wbv;
        logic [31:0] cnt;
        bit          chkWb;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mregs [NR];
    logic [31:0] mcount = '0;
    int          compared = 0;
    int          mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus: drive at the falling edge, predict, then advance the model
    // to the state it will hold after the following rising edge.
    task automatic drive(input bit rst, input bit m2r, input bit rw,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2,
                         input bit xSel);
        exp_t        e;
        logic [31:0] sel;
        bit          valid;
        @(negedge clk);
        reset     = rst;
        MemtoReg  = xSel ? 1'bx : m2r;
        RegWrite  = rw;
        AluIn     = alu;
        MemDataIn = mem;
        writeReg  = wr;
        readReg1  = r1;
        readReg2  = r2;
        if (rst) begin
            for (int i = 0; i < int'(NR); i++) mregs[i] = '0;
            mcount = '0;
        end
        sel   = m2r ? mem : alu;
        valid = rw && (wr != 5'd0);
        e.wbd   = sel;
        e.wbv   = valid;
        e.chkWb = !xSel;
        e.cnt   = mcount;
        e.rd1   = (rst || r1 == 5'd0) ? 32'd0 : ((valid && wr == r1) ? sel : mregs[r1]);
        e.rd2   = (rst || r2 == 5'd0) ? 32'd0 : ((valid && wr == r2) ? sel : mregs[r2]);
        sbq.push_back(e);
        if (!rst && valid) begin
            mregs[wr] = sel;
            mcount    = mcount + 32'd1;
        end
    endtask

    task automatic idle_read(input logic [4:0] r1, input logic [4:0] r2);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, r1, r2, 1'b0);
    endtask

    // Monitor: compare once per cycle, shortly after the stimulus settles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("readData1", readData1, e.rd1);
                check("readData2", readData2, e.rd2);
                check("wbValid", 32'(wbValid), 32'(e.wbv));
                check("wbCount", wbCount, e.cnt);
                if (e.chkWb) check("wbData", wbData, e.wbd);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  wr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        bit          rw;
        bit          rst;
        for (int i = 0; i < int'(NR); i++) mregs[i] = '0;

        // Reset state, then reset mid-run clearing a written register immediately
        drive(1'b1, 1'b0, 1'b1, 32'h5555, 32'h6666, 5'd5, 5'd5, 5'd6, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'hDEADBEEF, 5'd5, 5'd5, 5'd0, 1'b0);
        idle_read(5'd5, 5'd5);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd5, 5'd5, 1'b0);
        idle_read(5'd5, 5'd5);

        // Mux select both ways
        drive(1'b0, 1'b1, 1'b1, 32'h11, 32'h22, 5'd3, 5'd0, 5'd0, 1'b0);
        idle_read(5'd3, 5'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h11, 32'h22, 5'd3, 5'd4, 5'd0, 1'b0);
        idle_read(5'd3, 5'd3);

        // Bypass on port 1 while port 2 sees the old value
        drive(1'b0, 1'b0, 1'b1, 32'hAAAA, 32'h0, 5'd8, 5'd0, 5'd0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd7, 5'd7, 5'd8, 1'b0);
        idle_read(5'd7, 5'd8);

        // Zero register write is discarded and uncounted
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        idle_read(5'd0, 5'd3);

        // Back-to-back writes to one index, both ports on it
        drive(1'b0, 1'b0, 1'b1, 32'd1, 32'h0, 5'd9, 5'd9, 5'd9, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'd2, 32'h0, 5'd9, 5'd9, 5'd9, 1'b0);
        idle_read(5'd9, 5'd9);

        // Undefined MemtoReg with RegWrite low must leave state untouched
        drive(1'b0, 1'b0, 1'b0, 32'h77, 32'h88, 5'd9, 5'd9, 5'd3, 1'b1);
        idle_read(5'd9, 5'd3);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            rw  = ($urandom_range(0, 3) != 0);
            wr  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            r1  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? r1 : 5'($urandom_range(0, 31));
            drive(rst, 1'($urandom_range(0, 1)), rw, $urandom, $urandom, wr, r1, r2,
                  !rw && ($urandom_range(0, 7) == 0));
        end
        idle_read(5'd1, 5'd2);

        // Counter wrap via backdoor preload with the write path idle
        @(negedge clk);
        RegWrite = 1'b0;
        reset    = 1'b0;
        force dut.wbCount = 32'hFFFFFFFF;
        #2;
        release dut.wbCount;
        mcount = 32'hFFFFFFFF;
        drive(1'b0, 1'b0, 1'b1, 32'hCAFE, 32'h0, 5'd4, 5'd4, 5'd0, 1'b0);
        idle_read(5'd4, 5'd4);

        @(negedge clk);
        #3;
        compared++;
        if (sbq.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
